discr_pipe_scheduler: RTL and testbench
=======================================

Name: discr_pipe_scheduler

Overview:
- Round-robin scheduler that shares one fixed-latency discriminant pipeline among N_REQ requesters. The pipeline computes b*b - 4*a*c and has a 3-cycle latency in the current design.
- Accepts operand triples with a valid/ready handshake and issues at most one triple per cycle to the pipeline.
- Tracks the requester ID of each in-flight operation in an internal tag FIFO and routes each result back to the requester that issued it.
- Sits between the requesting blocks and the pipeline instance; it contains no arithmetic itself.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- TAG_DEPTH, 4, maximum outstanding operations (tag FIFO depth). Must be at least pipeline latency + 1 for full throughput.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  N_REQ  per-requester operand valid
- req_rdy  out  N_REQ  per-requester grant/ready; handshake = req_vld[i] & req_rdy[i]
- req_a  in  N_REQ*WIDTH  operand a, requester i in bits [i*WIDTH +: WIDTH]; same layout for req_b, req_c
- req_b  in  N_REQ*WIDTH  operand b
- req_c  in  N_REQ*WIDTH  operand c
- pipe_arg_vld  out  1  issue strobe to pipeline
- pipe_a, pipe_b, pipe_c  out  WIDTH each  issued operands
- pipe_res_vld  in  1  pipeline result valid
- pipe_res  in  WIDTH  pipeline result
- rsp_vld  out  N_REQ  one-hot result strobe to the owning requester
- rsp_res  out  WIDTH  result data, common to all requesters
- err  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, rst=1 at posedge): rr pointer=0, tag count=0, tag FIFO pointers=0, pipe_arg_vld=0, pipe_a/b/c=0, rsp_vld=0, rsp_res=0, err=0. Reset mid-operation discards all in-flight tags. Results arriving after reset are treated as errors (see below).
- Arbitration (combinational):
  - Grant the first i with req_vld[i]=1, searching from rr pointer upward with wrap-around modulo N_REQ.
  - req_rdy is one-hot or zero, and is asserted only to a requester with req_vld=1.
  - req_rdy is all-zero when issue is blocked.
- Issue blocked: tag count==TAG_DEPTH and no pop this cycle. A simultaneous pop while full permits issue.
- On a handshake with winner i, at the next posedge:
  - pipe_arg_vld=1 and pipe_a/b/c = requester i operands.
  - i is pushed into the tag FIFO.
  - rr pointer = (i+1) mod N_REQ.
- With no handshake: pipe_arg_vld=0, pipe_a/b/c hold their value, rr pointer holds.
- Result routing:
  - On pipe_res_vld=1 with count>0: pop head tag h. Next posedge: rsp_vld = one-hot(h), rsp_res = pipe_res.
  - Otherwise rsp_vld=0 and rsp_res holds.
- Error: pipe_res_vld=1 with count==0 (no simultaneous push counts) sets err=1, sticky until rst; no rsp_vld is asserted.
- Count update:
  - count += push - pop.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO pointers wrap modulo TAG_DEPTH.
- Ordering: the pipeline is in-order, so results return in issue order; the tag FIFO is strictly FIFO.
- Latency: handshake edge → pipe_arg_vld 1 cycle. pipe_res_vld → rsp_vld 1 cycle. End-to-end with a 3-stage pipeline: 5 cycles.
- Throughput: one issue per cycle when TAG_DEPTH >= 4.
- Arithmetic: none; data passes through at WIDTH bits unchanged.
- Requester-side rules:
  - A requester may drop req_vld without a handshake.
  - Operands are sampled only on the handshake edge.

Test Plan:
- Single request, bench uses a 3-stage pipeline model: req 0 with a=1, b=5, c=2, valid at cycle 0 → req_rdy[0]=1 at cycle 0; pipe_arg_vld at cycle 1; rsp_vld=4'b0001 with rsp_res=17 at cycle 5.
- Round-robin under full load: all four requesters held valid for 8 cycles, operands a=i, b=i+2, c=1 → grant order 0,1,2,3,0,1,2,3 with one issue per cycle; rsp_vld one-hots appear in the same order with rsp_res = (i+2)²-4i, i.e. 4, 5, 8, 13.
- Pointer fairness: only requesters 1 and 3 valid, rr pointer=2 → grant 3 first, then 1, then 3.
- Backpressure with TAG_DEPTH=2 and a 3-stage pipeline: requester 0 continuously valid → req_rdy pattern 1,1,0,0,1,1,… with never more than 2 outstanding; all results are delivered and none are lost.
- Error: pipe_res_vld=1 injected with the FIFO empty → err=1 next cycle, rsp_vld stays 0, err holds through later traffic until rst.
- Reset mid-flight: issue 3 requests, assert rst for 1 cycle before any result returns → all outputs 0 and count 0. The stale pipe_res_vld pulses that follow set err. New traffic after err is cleared by a second rst completes normally.

Source files
------------

// File: rtl/discr_pipe_scheduler_if.sv
// Bundle of requester, pipeline and response signals around the
// discriminant pipeline scheduler.
interface discr_pipe_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ-1:0]       req_rdy;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*WIDTH-1:0] req_c;
  logic                   pipe_arg_vld;
  logic [WIDTH-1:0]       pipe_a;
  logic [WIDTH-1:0]       pipe_b;
  logic [WIDTH-1:0]       pipe_c;
  logic                   pipe_res_vld;
  logic [WIDTH-1:0]       pipe_res;
  logic [N_REQ-1:0]       rsp_vld;
  logic [WIDTH-1:0]       rsp_res;
  logic                   err;

  // Scheduler side
  modport slave (
    input  req_vld, req_a, req_b, req_c, pipe_res_vld, pipe_res,
    output req_rdy, pipe_arg_vld, pipe_a, pipe_b, pipe_c, rsp_vld, rsp_res, err
  );

  // Requesters plus pipeline side
  modport master (
    output req_vld, req_a, req_b, req_c, pipe_res_vld, pipe_res,
    input  req_rdy, pipe_arg_vld, pipe_a, pipe_b, pipe_c, rsp_vld, rsp_res, err
  );
endinterface

// File: rtl/discr_pipe_scheduler.sv
// Round-robin issue of operand triples into a shared in-order pipeline,
// with a tag FIFO that routes each result back to its requester.
module discr_pipe_scheduler #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int TAG_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  discr_pipe_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win;
  logic             found;
  logic [IW-1:0]    tag_mem [TAG_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             blocked;
  logic [N_REQ-1:0] rdy;

  logic             arg_vld_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [N_REQ-1:0] rsp_vld_q;
  logic [WIDTH-1:0] rsp_res_q;
  logic             err_q;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IW-1:0];
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (int'(p) == TAG_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Scan downward so the requester closest to rr_ptr is the final winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_vld[rr_idx(rr_ptr, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_ptr, k);
      end
    end
  end

  assign pop     = bus.pipe_res_vld && (count != '0);
  assign blocked = (count == CW'(TAG_DEPTH)) && !pop;
  assign push    = found && !blocked;

  always_comb begin
    rdy = '0;
    if (push) rdy[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      arg_vld_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
      err_q     <= 1'b0;
    end else begin
      arg_vld_q <= push;
      if (push) begin
        a_q    <= bus.req_a[int'(win)*WIDTH +: WIDTH];
        b_q    <= bus.req_b[int'(win)*WIDTH +: WIDTH];
        c_q    <= bus.req_c[int'(win)*WIDTH +: WIDTH];
        wr_ptr <= ptr_inc(wr_ptr);
        rr_ptr <= rr_idx(win, 1);
      end
      rsp_vld_q <= '0;
      if (pop) begin
        rsp_vld_q[tag_mem[rd_ptr]] <= 1'b1;
        rsp_res_q                  <= bus.pipe_res;
        rd_ptr                     <= ptr_inc(rd_ptr);
      end
      // A result with nothing outstanding can only be stale or spurious
      if (bus.pipe_res_vld && (count == '0)) err_q <= 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= win;
  end

  assign bus.req_rdy      = rdy;
  assign bus.pipe_arg_vld = arg_vld_q;
  assign bus.pipe_a       = a_q;
  assign bus.pipe_b       = b_q;
  assign bus.pipe_c       = c_q;
  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_res      = rsp_res_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_discr_pipe_scheduler.sv
// Directed bench: two schedulers (tag depth 4 and 2), each fed by a
// 3-stage discriminant pipeline model.
module tb_discr_pipe_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inj = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  discr_pipe_scheduler_if #(.N_REQ(4), .WIDTH(32)) if1 ();
  discr_pipe_scheduler_if #(.N_REQ(4), .WIDTH(32)) if2 ();

  discr_pipe_scheduler #(.N_REQ(4), .WIDTH(32), .TAG_DEPTH(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
  discr_pipe_scheduler #(.N_REQ(4), .WIDTH(32), .TAG_DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  // Pipeline models are deliberately not reset so stale results survive rst
  logic [2:0]  m1_vld = '0;
  logic [31:0] m1_res [3];
  logic [2:0]  m2_vld = '0;
  logic [31:0] m2_res [3];

  always @(posedge clk) begin
    m1_vld    <= {m1_vld[1:0], if1.pipe_arg_vld};
    m1_res[0] <= if1.pipe_b * if1.pipe_b - 32'd4 * if1.pipe_a * if1.pipe_c;
    m1_res[1] <= m1_res[0];
    m1_res[2] <= m1_res[1];
    m2_vld    <= {m2_vld[1:0], if2.pipe_arg_vld};
    m2_res[0] <= if2.pipe_b * if2.pipe_b - 32'd4 * if2.pipe_a * if2.pipe_c;
    m2_res[1] <= m2_res[0];
    m2_res[2] <= m2_res[1];
  end

  assign if1.pipe_res_vld = m1_vld[2] | inj;
  assign if1.pipe_res     = m1_res[2];
  assign if2.pipe_res_vld = m2_vld[2];
  assign if2.pipe_res     = m2_res[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    if1.req_vld = '0;
    if1.req_a = '0;
    if1.req_b = '0;
    if1.req_c = '0;
    if2.req_vld = '0;
    if2.req_a = '0;
    if2.req_b = '0;
    if2.req_c = '0;
    rst = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    n_cmp++; if (if1.pipe_arg_vld !== 1'b0) begin n_bad++; $display("FAIL reset_arg_vld got=%b exp=0", if1.pipe_arg_vld); end
    n_cmp++; if (if1.pipe_a !== 32'd0) begin n_bad++; $display("FAIL reset_pipe_a got=%0d exp=0", if1.pipe_a); end
    n_cmp++; if (if1.rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_vld got=%b exp=0000", if1.rsp_vld); end
    n_cmp++; if (if1.rsp_res !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_res got=%0d exp=0", if1.rsp_res); end
    n_cmp++; if (if1.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", if1.err); end
    n_cmp++; if (if1.req_rdy !== 4'b0000) begin n_bad++; $display("FAIL reset_rdy got=%b exp=0000", if1.req_rdy); end
    n_cmp++; if (if2.err !== 1'b0) begin n_bad++; $display("FAIL reset_err2 got=%b exp=0", if2.err); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    if1.req_a[0 +: 32] = 32'd1;
    if1.req_b[0 +: 32] = 32'd5;
    if1.req_c[0 +: 32] = 32'd2;
    if1.req_vld = 4'b0001;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      n_cmp++; if (if1.req_rdy !== ((cyc == 0) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL single_rdy cyc=%0d got=%b", cyc, if1.req_rdy); end
      n_cmp++; if (if1.pipe_arg_vld !== (cyc == 1)) begin n_bad++; $display("FAIL single_arg_vld cyc=%0d got=%b", cyc, if1.pipe_arg_vld); end
      n_cmp++; if (if1.rsp_vld !== ((cyc == 5) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL single_rsp_vld cyc=%0d got=%b", cyc, if1.rsp_vld); end
      if (cyc == 5) begin
        n_cmp++; if (if1.rsp_res !== 32'd17) begin n_bad++; $display("FAIL single_rsp_res got=%0d exp=17", if1.rsp_res); end
      end
      tick();
      if1.req_vld = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_res [4];
    exp_res[0] = 32'd4; exp_res[1] = 32'd5; exp_res[2] = 32'd8; exp_res[3] = 32'd13;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if1.req_a[i*32 +: 32] = i;
      if1.req_b[i*32 +: 32] = i + 2;
      if1.req_c[i*32 +: 32] = 32'd1;
    end
    if1.req_vld = 4'b1111;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        n_cmp++; if (if1.req_rdy !== (4'b0001 << (cyc % 4))) begin n_bad++; $display("FAIL rr_rdy cyc=%0d got=%b exp=%b", cyc, if1.req_rdy, 4'b0001 << (cyc % 4)); end
      end
      if (cyc >= 1 && cyc <= 8) begin
        n_cmp++; if (if1.pipe_a !== 32'((cyc - 1) % 4)) begin n_bad++; $display("FAIL rr_pipe_a cyc=%0d got=%0d exp=%0d", cyc, if1.pipe_a, (cyc - 1) % 4); end
      end
      if (cyc >= 5 && cyc <= 12) begin
        n_cmp++; if (if1.rsp_vld !== (4'b0001 << ((cyc - 5) % 4))) begin n_bad++; $display("FAIL rr_rsp_vld cyc=%0d got=%b", cyc, if1.rsp_vld); end
        n_cmp++; if (if1.rsp_res !== exp_res[(cyc - 5) % 4]) begin n_bad++; $display("FAIL rr_rsp_res cyc=%0d got=%0d exp=%0d", cyc, if1.rsp_res, exp_res[(cyc - 5) % 4]); end
      end else begin
        n_cmp++; if (if1.rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL rr_rsp_idle cyc=%0d got=%b", cyc, if1.rsp_vld); end
      end
      tick();
      if (cyc == 7) if1.req_vld = 4'b0000;
    end
  endtask

  // rr pointer is 0 on entry; one grant to requester 1 moves it to 2
  task automatic test_pointer_fairness();
    logic [3:0] vld_tab [10];
    logic [3:0] rdy_tab [10];
    logic [3:0] rsp_tab [10];
    logic [31:0] res_tab [10];
    for (int i = 0; i < 10; i++) begin
      vld_tab[i] = 4'b0000; rdy_tab[i] = 4'b0000; rsp_tab[i] = 4'b0000; res_tab[i] = 32'd0;
    end
    vld_tab[0] = 4'b0010; vld_tab[1] = 4'b1010; vld_tab[2] = 4'b1010; vld_tab[3] = 4'b1010;
    rdy_tab[0] = 4'b0010; rdy_tab[1] = 4'b1000; rdy_tab[2] = 4'b0010; rdy_tab[3] = 4'b1000;
    rsp_tab[5] = 4'b0010; rsp_tab[6] = 4'b1000; rsp_tab[7] = 4'b0010; rsp_tab[8] = 4'b1000;
    res_tab[5] = 32'd5;   res_tab[6] = 32'd13;  res_tab[7] = 32'd5;   res_tab[8] = 32'd13;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if1.req_vld = vld_tab[cyc];
      @(negedge clk);
      n_cmp++; if (if1.req_rdy !== rdy_tab[cyc]) begin n_bad++; $display("FAIL fair_rdy cyc=%0d got=%b exp=%b", cyc, if1.req_rdy, rdy_tab[cyc]); end
      n_cmp++; if (if1.rsp_vld !== rsp_tab[cyc]) begin n_bad++; $display("FAIL fair_rsp_vld cyc=%0d got=%b exp=%b", cyc, if1.rsp_vld, rsp_tab[cyc]); end
      if (rsp_tab[cyc] != 4'b0000) begin
        n_cmp++; if (if1.rsp_res !== res_tab[cyc]) begin n_bad++; $display("FAIL fair_rsp_res cyc=%0d got=%0d exp=%0d", cyc, if1.rsp_res, res_tab[cyc]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int issued = 0;
    int res_seen = 0;
    int rsp_seen = 0;
    do_reset();
    if2.req_a[0 +: 32] = 32'd1;
    if2.req_b[0 +: 32] = 32'd5;
    if2.req_c[0 +: 32] = 32'd2;
    if2.req_vld = 4'b0001;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc == 12) if2.req_vld = 4'b0000;
      @(negedge clk);
      if (cyc < 12) begin
        n_cmp++; if (if2.req_rdy !== (((cyc % 4) < 2) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL bp_rdy cyc=%0d got=%b", cyc, if2.req_rdy); end
      end
      n_cmp++; if (issued - res_seen > 2) begin n_bad++; $display("FAIL bp_outstanding cyc=%0d got=%0d exp<=2", cyc, issued - res_seen); end
      if (if2.rsp_vld != 4'b0000) begin
        rsp_seen++;
        n_cmp++; if (if2.rsp_vld !== 4'b0001 || if2.rsp_res !== 32'd17) begin n_bad++; $display("FAIL bp_rsp cyc=%0d got=%b/%0d exp=0001/17", cyc, if2.rsp_vld, if2.rsp_res); end
      end
      if ((if2.req_vld[0] & if2.req_rdy[0]) === 1'b1) issued++;
      if (if2.pipe_res_vld === 1'b1) res_seen++;
      tick();
    end
    n_cmp++; if (issued !== 6) begin n_bad++; $display("FAIL bp_issued got=%0d exp=6", issued); end
    n_cmp++; if (rsp_seen !== 6) begin n_bad++; $display("FAIL bp_delivered got=%0d exp=6", rsp_seen); end
  endtask

  task automatic test_error();
    do_reset();
    inj = 1'b1;
    @(negedge clk);
    n_cmp++; if (if1.err !== 1'b0) begin n_bad++; $display("FAIL err_pre got=%b exp=0", if1.err); end
    tick();
    inj = 1'b0;
    // requester 0 still holds a=0, b=2, c=1 -> 4
    if1.req_vld = 4'b0001;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(negedge clk);
      n_cmp++; if (if1.err !== 1'b1) begin n_bad++; $display("FAIL err_sticky cyc=%0d got=%b exp=1", cyc, if1.err); end
      n_cmp++; if (if1.rsp_vld !== ((cyc == 6) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL err_rsp_vld cyc=%0d got=%b", cyc, if1.rsp_vld); end
      tick();
      if1.req_vld = 4'b0000;
    end
    do_reset();
    @(negedge clk);
    n_cmp++; if (if1.err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", if1.err); end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    if1.req_vld = 4'b0111;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc == 3) begin rst = 1'b1; if1.req_vld = 4'b0000; end
      if (cyc == 4) rst = 1'b0;
      @(negedge clk);
      if (cyc < 3) begin
        n_cmp++; if (if1.req_rdy !== (4'b0001 << cyc)) begin n_bad++; $display("FAIL mid_rdy cyc=%0d got=%b", cyc, if1.req_rdy); end
      end
      if (cyc == 4) begin
        n_cmp++; if (if1.pipe_arg_vld !== 1'b0 || if1.pipe_a !== 32'd0 || if1.pipe_b !== 32'd0 || if1.pipe_c !== 32'd0) begin n_bad++; $display("FAIL mid_pipe_zero got=%b/%0d/%0d/%0d", if1.pipe_arg_vld, if1.pipe_a, if1.pipe_b, if1.pipe_c); end
        n_cmp++; if (if1.rsp_vld !== 4'b0000 || if1.rsp_res !== 32'd0) begin n_bad++; $display("FAIL mid_rsp_zero got=%b/%0d", if1.rsp_vld, if1.rsp_res); end
        n_cmp++; if (if1.err !== 1'b0) begin n_bad++; $display("FAIL mid_err_zero got=%b", if1.err); end
      end
      if (cyc >= 5) begin
        n_cmp++; if (if1.err !== 1'b1) begin n_bad++; $display("FAIL mid_stale_err cyc=%0d got=%b exp=1", cyc, if1.err); end
        n_cmp++; if (if1.rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL mid_stale_rsp cyc=%0d got=%b", cyc, if1.rsp_vld); end
      end
      tick();
    end
    do_reset();
    if1.req_vld = 4'b0001;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      n_cmp++; if (if1.err !== 1'b0) begin n_bad++; $display("FAIL mid_new_err cyc=%0d got=%b", cyc, if1.err); end
      n_cmp++; if (if1.rsp_vld !== ((cyc == 5) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL mid_new_rsp cyc=%0d got=%b", cyc, if1.rsp_vld); end
      if (cyc == 5) begin
        n_cmp++; if (if1.rsp_res !== 32'd4) begin n_bad++; $display("FAIL mid_new_res got=%0d exp=4", if1.rsp_res); end
      end
      tick();
      if1.req_vld = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_fairness();
    test_backpressure();
    test_error();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
